// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package hazard_ctrl_pkg;

  // Sequencer state. RUN issues or RAW-stalls. FLUSH kills wrong-path fetch/decode work.
  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_FLUSH = 1'b1
  } hz_state_t;

  // Register-file address width (x0..x31).
  localparam int REG_AW = 5;

  // x0 is hardwired to zero. It never carries a dependency and never needs a slot.
  function automatic logic reg_nz(input logic [REG_AW-1:0] a);
    return a != '0;
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// In-flight destination tracker: NSLOT-deep {valid,addr} shift register plus two RAW compare ports.
// Latency: hits are combinational from the stored slots; an insert becomes visible the next cycle.
// Backpressure: hold=1 freezes every slot; otherwise the pipe shifts each cycle and slot[NSLOT-1] drops out.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all slots)
//   hold                freeze the shift register this cycle
//   ins_vld, ins_addr   entry written into slot[0] on a shift
//   rs1_addr, rs2_addr  source registers to compare
//   hit_rs1, hit_rs2    a valid slot matches a non-zero source register
module hazard_slot_pipe
  import hazard_ctrl_pkg::*;
#(
  parameter int NSLOT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              ins_vld,
  input  logic [REG_AW-1:0] ins_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              hit_rs1,
  output logic              hit_rs2
);

  logic [NSLOT-1:0]  slot_vld;
  logic [REG_AW-1:0] slot_addr [NSLOT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_addr[i] <= '0;
      end
    end else if (!hold) begin
      // slot[0] is the youngest entry (the instruction now in EX).
      slot_vld[0]  <= ins_vld;
      slot_addr[0] <= ins_addr;
      for (int i = 1; i < NSLOT; i++) begin
        slot_vld[i]  <= slot_vld[i-1];
        slot_addr[i] <= slot_addr[i-1];
      end
    end
  end

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_vld[i] && (slot_addr[i] == rs1_addr) && reg_nz(rs1_addr)) begin
        hit_rs1 = 1'b1;
      end
      if (slot_vld[i] && (slot_addr[i] == rs2_addr) && reg_nz(rs2_addr)) begin
        hit_rs2 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencer: RAW stall, post-redirect flush, and whole-pipe freeze while memory is busy.
// Latency: stall_flg/id_bubble/if_kill are combinational (0 cycles); state and counters update at the clock edge.
// Backpressure: mem_busy wins over everything and freezes slots, state and counters; redirect beats RAW.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   id_valid                            decode holds a real instruction
//   id_rs1_addr/used, id_rs2_addr/used  source operands of the decode instruction
//   id_rf_wen, id_wb_addr               destination of the decode instruction
//   ex_redirect                         EX changes PC this cycle
//   mem_busy                            MEM cannot complete this cycle
//   stall_flg                           fetch/decode hold and replay the saved instruction
//   id_bubble                           EX captures a NOP instead of decode output
//   if_kill                             fetch discards its output
//   stall_cycles, flush_count           wrapping performance counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NSLOT        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs2_used,
  input  logic              id_rf_wen,
  input  logic [REG_AW-1:0] id_wb_addr,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              stall_flg,
  output logic              id_bubble,
  output logic              if_kill,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  // FLUSH_CYCLES is limited to 1..7, so three bits always hold the countdown.
  localparam int              FC_W     = 3;
  localparam logic [FC_W-1:0] FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hz_state_t       state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  logic hit_rs1, hit_rs2, raw;
  logic slot_hold, slot_ins_vld;
  logic stall_c, bubble_c, kill_c;
  logic stall_inc, flush_inc;

  hazard_slot_pipe #(
    .NSLOT (NSLOT)
  ) u_slot_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (slot_hold),
    .ins_vld  (slot_ins_vld),
    .ins_addr (id_wb_addr),
    .rs1_addr (id_rs1_addr),
    .rs2_addr (id_rs2_addr),
    .hit_rs1  (hit_rs1),
    .hit_rs2  (hit_rs2)
  );

  assign raw = id_valid && ((id_rs1_used && hit_rs1) || (id_rs2_used && hit_rs2));

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    stall_c      = 1'b0;
    bubble_c     = 1'b0;
    kill_c       = 1'b0;
    slot_hold    = 1'b0;
    slot_ins_vld = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (mem_busy) begin
      // Whole pipe frozen. EX keeps any redirect and presents it again once MEM frees up.
      stall_c   = 1'b1;
      slot_hold = 1'b1;
    end else if (ex_redirect) begin
      // A redirect during FLUSH restarts the countdown.
      kill_c    = 1'b1;
      bubble_c  = 1'b1;
      state_d   = HZ_FLUSH;
      fcnt_d    = FC_LOAD;
      flush_inc = 1'b1;
    end else if (state_q == HZ_FLUSH) begin
      kill_c   = 1'b1;
      bubble_c = 1'b1;
      if (fcnt_q == '0) begin
        state_d = HZ_RUN;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
      end
    end else if (raw) begin
      // Older producers keep draining behind the bubble while decode replays.
      stall_c   = 1'b1;
      bubble_c  = 1'b1;
      stall_inc = 1'b1;
    end else begin
      slot_ins_vld = id_valid && id_rf_wen && reg_nz(id_wb_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HZ_RUN;
      fcnt_q       <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_inc) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if (flush_inc) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end
  end

  // While reset is asserted EX is fed NOPs and fetch and decode are left free.
  assign stall_flg = rst_n & stall_c;
  assign id_bubble = ~rst_n | bubble_c;
  assign if_kill   = rst_n & kill_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic        id_rs1_used;
  logic [4:0]  id_rs2_addr;
  logic        id_rs2_used;
  logic        id_rf_wen;
  logic [4:0]  id_wb_addr;
  logic        ex_redirect;
  logic        mem_busy;
  logic        stall_flg;
  logic        id_bubble;
  logic        if_kill;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NSLOT        (3),
    .FLUSH_CYCLES (2),
    .CNT_W        (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs2_used  (id_rs2_used),
    .id_rf_wen    (id_rf_wen),
    .id_wb_addr   (id_wb_addr),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .stall_flg    (stall_flg),
    .id_bubble    (id_bubble),
    .if_kill      (if_kill),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // Expected {stall_flg, id_bubble, if_kill} per cycle, queued when driven, popped when sampled.
  typedef struct {
    logic [2:0] sbk;
    int         tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       wen;
    logic [4:0] wb;
    logic       red;
    logic       busy;
    logic [2:0] sbk;
  } vec_t;
  vec_t vecs[10];

  task automatic set_in(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic wen,
                        input logic [4:0] wb, input logic red, input logic busy);
    id_valid    = v;
    id_rs1_addr = r1;
    id_rs1_used = u1;
    id_rs2_addr = r2;
    id_rs2_used = u2;
    id_rf_wen   = wen;
    id_wb_addr  = wb;
    ex_redirect = red;
    mem_busy    = busy;
  endtask

  // Current inputs are already driven; queue the expectation, sample at the falling edge,
  // then advance to just after the next rising edge.
  task automatic step(input logic [2:0] want, input int tag);
    exp_t e;
    e.sbk = want;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty tag=%0d", tag);
    end else begin
      e = sb.pop_front();
      if ({stall_flg, id_bubble, if_kill} !== e.sbk) begin
        n_errors++;
        $display("FAIL outputs tag=%0d stall/bubble/kill got %b want %b",
                 e.tag, {stall_flg, id_bubble, if_kill}, e.sbk);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic idle(input int n, input int tag);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step(3'b000, tag);
  endtask

  initial begin
    // addi x5,x0,1 then add x6,x5,x0 (three stall cycles, then issue)
    vecs[0] = '{1, 5'd0, 1, 5'd0, 0, 1, 5'd5, 0, 0, 3'b000};
    vecs[1] = '{1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0, 3'b110};
    vecs[2] = '{1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0, 3'b110};
    vecs[3] = '{1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0, 3'b110};
    vecs[4] = '{1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0, 3'b000};
    // addi x0,x0,1 records nothing; a reader of x0 never stalls
    vecs[5] = '{1, 5'd0, 1, 5'd0, 0, 1, 5'd0, 0, 0, 3'b000};
    vecs[6] = '{1, 5'd0, 1, 5'd0, 1, 1, 5'd7, 0, 0, 3'b000};
    // invalid decode slot never stalls even with a matching source
    vecs[7] = '{0, 5'd7, 1, 5'd6, 1, 0, 5'd0, 0, 0, 3'b000};
    vecs[8] = '{0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 3'b000};
    vecs[9] = '{0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 3'b000};

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(3'b010, 100);
    chk_cnt("reset_stall_cycles", stall_cycles, 0);
    chk_cnt("reset_flush_count", flush_count, 0);
    rst_n = 1'b1;

    // Tests 1 and 2: table-driven
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].valid, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2,
             vecs[i].wen, vecs[i].wb, vecs[i].red, vecs[i].busy);
      step(vecs[i].sbk, i);
    end
    chk_cnt("t1_stall_cycles", stall_cycles, 3);
    chk_cnt("t1_flush_count", flush_count, 0);

    // Test 3: redirect in RUN -> redirect cycle plus two FLUSH cycles, then RUN
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(3'b011, 300);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(3'b011, 301);
    step(3'b011, 302);
    step(3'b000, 303);
    chk_cnt("t3_flush_count", flush_count, 1);

    // Test 4: hazard pending behind mem_busy for five cycles; frozen cycles do not count
    set_in(1, 5'd0, 1, 5'd0, 0, 1, 5'd5, 0, 0);
    step(3'b000, 400);
    set_in(1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 1);
    for (int i = 0; i < 5; i++) step(3'b100, 410 + i);
    chk_cnt("t4_stall_frozen", stall_cycles, 3);
    set_in(1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0);
    for (int i = 0; i < 3; i++) step(3'b110, 420 + i);
    step(3'b000, 423);
    chk_cnt("t4_stall_cycles", stall_cycles, 6);
    idle(3, 430);

    // Test 5: redirect coincides with raw -> flush wins, x5 slot drains during FLUSH
    set_in(1, 5'd0, 1, 5'd0, 0, 1, 5'd5, 0, 0);
    step(3'b000, 500);
    set_in(1, 5'd0, 0, 5'd5, 1, 0, 5'd0, 1, 0);
    step(3'b011, 501);
    set_in(1, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0, 0);
    step(3'b011, 502);
    step(3'b011, 503);
    step(3'b000, 504);
    chk_cnt("t5_stall_cycles", stall_cycles, 6);
    chk_cnt("t5_flush_count", flush_count, 2);
    idle(3, 510);

    // Test 6: reset mid-FLUSH with two valid slots
    set_in(1, 5'd0, 1, 5'd0, 0, 1, 5'd5, 0, 0);
    step(3'b000, 600);
    set_in(1, 5'd0, 1, 5'd0, 0, 1, 5'd7, 0, 0);
    step(3'b000, 601);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(3'b011, 602);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(3'b010, 603);
    chk_cnt("t6_stall_cycles", stall_cycles, 0);
    chk_cnt("t6_flush_count", flush_count, 0);
    rst_n = 1'b1;
    set_in(1, 5'd5, 1, 5'd7, 1, 1, 5'd8, 0, 0);
    step(3'b000, 604);
    chk_cnt("t6_no_stall_count", stall_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
